// File: rtl/speed_tick_scheduler_if.sv
// Control/status bundle for speed_tick_scheduler.
// master: game controller (drives start/pause/stop, observes tick/level/period).
// slave:  the scheduler itself.
interface speed_tick_scheduler_if #(
  parameter int unsigned CW = 32
);
  logic          start;
  logic          pause;
  logic          stop;
  logic          tick;
  logic          running;
  logic [7:0]    level;
  logic [CW-1:0] period;

  modport master (
    output start, pause, stop,
    input  tick, running, level, period
  );

  modport slave (
    input  start, pause, stop,
    output tick, running, level, period
  );
endinterface

// File: rtl/speed_tick_scheduler.sv
// Game-speed tick scheduler: emits a one-cycle clock-enable "tick" every
// `period` sysclk cycles while running. IDLE/RUN/PAUSED FSM, priority
// stop > pause > start. Pause preserves the counter phase.
// Optional difficulty ramp (level counter + shrinking period) is compiled in
// only when macro SPEED_TICK_RAMP_EN is defined; otherwise level is 0 and
// period is the constant PERIOD_INIT.
module speed_tick_scheduler #(
  parameter int unsigned CW              = 32,
  parameter int unsigned PERIOD_INIT     = 1000000,
  parameter int unsigned PERIOD_MIN      = 250000,
  parameter int unsigned PERIOD_STEP     = 50000,
  parameter int unsigned TICKS_PER_LEVEL = 500
) (
  input logic                  sysclk,
  input logic                  rst_n,
  speed_tick_scheduler_if.slave bus
);

  // Reject parameter sets the counter cannot represent.
  if (PERIOD_MIN < 32'd2) begin : g_chk_min
    $error("speed_tick_scheduler: PERIOD_MIN must be >= 2");
  end
  if (PERIOD_INIT < PERIOD_MIN) begin : g_chk_init
    $error("speed_tick_scheduler: PERIOD_INIT must be >= PERIOD_MIN");
  end
  if ((CW < 32'd32) && (PERIOD_INIT >= (32'd1 << CW))) begin : g_chk_cw
    $error("speed_tick_scheduler: PERIOD_INIT does not fit in CW bits");
  end
  if ((CW < 32'd32) && (PERIOD_STEP >= (32'd1 << CW))) begin : g_chk_step
    $error("speed_tick_scheduler: PERIOD_STEP does not fit in CW bits");
  end
  if (TICKS_PER_LEVEL < 32'd1) begin : g_chk_tpl
    $error("speed_tick_scheduler: TICKS_PER_LEVEL must be >= 1");
  end

  localparam logic [CW-1:0] P_INIT = CW'(PERIOD_INIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t        state_r, state_nx_s;
  logic [CW-1:0] cnt_r, cnt_nx_s;
  logic          tick_r, tick_nx_s;
  logic          running_r;
  logic [CW-1:0] period_cur_s;
  logic          wrap_s;

  // Next-state logic with stop > pause > start priority.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.stop || bus.pause) state_nx_s = IDLE;
        else if (bus.start)        state_nx_s = RUN;
        else                       state_nx_s = IDLE;
      end
      RUN: begin
        if (bus.stop)       state_nx_s = IDLE;
        else if (bus.pause) state_nx_s = PAUSED;
        else                state_nx_s = RUN;
      end
      PAUSED: begin
        if (bus.stop)        state_nx_s = IDLE;
        else if (bus.pause)  state_nx_s = PAUSED;
        else if (bus.start)  state_nx_s = RUN;
        else                 state_nx_s = PAUSED;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  assign wrap_s = (state_r == RUN) && (cnt_r == (period_cur_s - CW'(1)));

  // Interval counter and tick decision. A wrap that coincides with pause is
  // held at period-1 so the suppressed tick fires on the first RUN cycle.
  always_comb begin
    cnt_nx_s  = cnt_r;
    tick_nx_s = 1'b0;
    if (state_nx_s == IDLE) begin
      cnt_nx_s = '0;
    end else if (state_r == RUN) begin
      if (wrap_s) begin
        if (state_nx_s == RUN) begin
          cnt_nx_s  = '0;
          tick_nx_s = 1'b1;
        end else begin
          cnt_nx_s = cnt_r;
        end
      end else begin
        cnt_nx_s = cnt_r + CW'(1);
      end
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      tick_r    <= tick_nx_s;
      running_r <= (state_nx_s == RUN);
    end
  end

  assign bus.tick    = tick_r;
  assign bus.running = running_r;

`ifdef SPEED_TICK_RAMP_EN
  localparam int unsigned   TW     = $clog2(TICKS_PER_LEVEL + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TICKS_PER_LEVEL - 1);
  localparam logic [CW-1:0] P_MIN  = CW'(PERIOD_MIN);
  localparam logic [CW-1:0] P_STEP = CW'(PERIOD_STEP);

  logic [TW-1:0] tcnt_r, tcnt_nx_s;
  logic [7:0]    level_r, level_nx_s;
  logic [CW-1:0] period_r, period_nx_s;

  // Level-up bookkeeping; the floor test uses period-PERIOD_MIN so no
  // intermediate value can wrap below zero.
  always_comb begin
    tcnt_nx_s   = tcnt_r;
    level_nx_s  = level_r;
    period_nx_s = period_r;
    if (state_nx_s == IDLE) begin
      tcnt_nx_s   = '0;
      level_nx_s  = 8'd0;
      period_nx_s = P_INIT;
    end else if (tick_nx_s) begin
      if (tcnt_r == T_LAST) begin
        tcnt_nx_s  = '0;
        level_nx_s = (level_r == 8'hFF) ? level_r : (level_r + 8'd1);
        if ((period_r - P_MIN) >= P_STEP) period_nx_s = period_r - P_STEP;
        else                              period_nx_s = P_MIN;
      end else begin
        tcnt_nx_s = tcnt_r + TW'(1);
      end
    end else begin
      tcnt_nx_s = tcnt_r;
    end
  end

  // Ramp registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_r   <= '0;
      level_r  <= 8'd0;
      period_r <= P_INIT;
    end else begin
      tcnt_r   <= tcnt_nx_s;
      level_r  <= level_nx_s;
      period_r <= period_nx_s;
    end
  end

  assign period_cur_s = period_r;
  assign bus.level    = level_r;
  assign bus.period   = period_r;
`else
  assign period_cur_s = P_INIT;
  assign bus.level    = 8'd0;
  assign bus.period   = P_INIT;
`endif

endmodule

// File: tb/tb_speed_tick_scheduler.sv
// Self-checking bench for speed_tick_scheduler (PERIOD_INIT=10, PERIOD_MIN=4,
// PERIOD_STEP=3, TICKS_PER_LEVEL=2). Expectations follow SPEED_TICK_RAMP_EN.
module tb_speed_tick_scheduler;
  localparam int CW = 16;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b1;

  speed_tick_scheduler_if #(.CW(CW)) bus ();

  speed_tick_scheduler #(
    .CW(CW), .PERIOD_INIT(10), .PERIOD_MIN(4), .PERIOD_STEP(3), .TICKS_PER_LEVEL(2)
  ) dut (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic        start;
    logic        pause;
    logic        stop;
    int          cycles;
    int          exp_ticks;
    logic        exp_running;
    logic [7:0]  exp_level;
    logic [15:0] exp_period;
  } vec_t;

  vec_t vecs[7];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   ticks_seen = 0;
  int   exp_q[$];
  int   base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock; sample #1 after the edge and score any tick against the queue.
  task automatic step();
    @(posedge sysclk);
    #1;
    cyc++;
    if (bus.tick === 1'b1) begin
      ticks_seen++;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_tick: tick at cycle %0d, none expected", cyc);
      end else begin
        chk("tick_time", cyc, exp_q.pop_front());
      end
    end
  endtask

  task automatic drain(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.stop  = 1'b0;

    // Row table: main run from a start pulse, then start-in-RUN, then stop+pause+start.
`ifdef SPEED_TICK_RAMP_EN
    vecs[0] = '{1'b1, 1'b0, 1'b0,  1, 0, 1'b1, 8'd0, 16'd10};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 20, 2, 1'b1, 8'd1, 16'd7};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 14, 2, 1'b1, 8'd2, 16'd4};
    vecs[3] = '{1'b0, 1'b0, 1'b0,  8, 2, 1'b1, 8'd3, 16'd4};
    vecs[4] = '{1'b1, 1'b0, 1'b0,  3, 0, 1'b1, 8'd3, 16'd4};
`else
    vecs[0] = '{1'b1, 1'b0, 1'b0,  1, 0, 1'b1, 8'd0, 16'd10};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 20, 2, 1'b1, 8'd0, 16'd10};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 14, 1, 1'b1, 8'd0, 16'd10};
    vecs[3] = '{1'b0, 1'b0, 1'b0,  8, 1, 1'b1, 8'd0, 16'd10};
    vecs[4] = '{1'b1, 1'b0, 1'b0,  3, 0, 1'b1, 8'd0, 16'd10};
`endif
    vecs[5] = '{1'b1, 1'b1, 1'b1,  1, 0, 1'b0, 8'd0, 16'd10};
    vecs[6] = '{1'b0, 1'b0, 1'b0,  5, 0, 1'b0, 8'd0, 16'd10};

    // Asynchronous reset with no clock edge involved.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tick", bus.tick, 1'b0);
    chk("rst_running", bus.running, 1'b0);
    chk("rst_level", bus.level, 8'd0);
    chk("rst_period", bus.period, 16'd10);
    repeat (2) @(posedge sysclk);
    @(negedge sysclk) rst_n = 1'b1;

    // Stay idle until start; pause outranks start in IDLE.
    repeat (5) step();
    chk("idle_running", bus.running, 1'b0);
    bus.pause = 1'b1; bus.start = 1'b1;
    step();
    chk("idle_pause_prio", bus.running, 1'b0);
    bus.pause = 1'b0; bus.start = 1'b0;
    step();

    // Table-driven main run; expected tick cycles pushed when start is driven.
    for (int i = 0; i < 7; i++) begin
      bus.start = vecs[i].start;
      bus.pause = vecs[i].pause;
      bus.stop  = vecs[i].stop;
      if (i == 0) begin
        base = cyc + 1;
`ifdef SPEED_TICK_RAMP_EN
        exp_q.push_back(base + 10); exp_q.push_back(base + 20);
        exp_q.push_back(base + 27); exp_q.push_back(base + 34);
        exp_q.push_back(base + 38); exp_q.push_back(base + 42);
`else
        exp_q.push_back(base + 10); exp_q.push_back(base + 20);
        exp_q.push_back(base + 30); exp_q.push_back(base + 40);
`endif
      end
      ticks_seen = 0;
      repeat (vecs[i].cycles) step();
      chk($sformatf("row%0d_ticks", i), ticks_seen, vecs[i].exp_ticks);
      chk($sformatf("row%0d_running", i), bus.running, vecs[i].exp_running);
      chk($sformatf("row%0d_level", i), bus.level, vecs[i].exp_level);
      chk($sformatf("row%0d_period", i), bus.period, vecs[i].exp_period);
    end
    drain("run_drain");
    bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;

    // Pause sampled while counter is at period-1: tick deferred to first RUN cycle.
    bus.start = 1'b1;
    step();
    base = cyc;
    bus.start = 1'b0;
    exp_q.push_back(base + 13);
    repeat (9) step();
    bus.pause = 1'b1;
    step();
    chk("pause9_running", bus.running, 1'b0);
    step();
    bus.pause = 1'b0; bus.start = 1'b1;
    step();
    chk("pause9_resume", bus.running, 1'b1);
    bus.start = 1'b0;
    step();
    chk("pause9_tick", bus.tick, 1'b1);
    drain("pause9_drain");
    bus.stop = 1'b1; step(); bus.stop = 1'b0; step();

    // Pause held 5 cycles mid-interval: next tick 5 cycles late.
    bus.start = 1'b1;
    step();
    base = cyc;
    bus.start = 1'b0;
    exp_q.push_back(base + 15);
    repeat (3) step();
    bus.pause = 1'b1;
    repeat (5) step();
    chk("pause3_running", bus.running, 1'b0);
    bus.pause = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("pause3_resume", bus.running, 1'b1);
    repeat (6) step();
    drain("pause3_drain");
    bus.stop = 1'b1; step(); bus.stop = 1'b0; step();

    // Asynchronous reset mid-RUN, right after a tick edge.
    bus.start = 1'b1;
    step();
    base = cyc;
    bus.start = 1'b0;
    exp_q.push_back(base + 10); exp_q.push_back(base + 20);
    repeat (20) step();
    #1;
    chk("prereset_tick", bus.tick, 1'b1);
`ifdef SPEED_TICK_RAMP_EN
    chk("prereset_level", bus.level, 8'd1);
`endif
    rst_n = 1'b0;
    #1;
    chk("async_tick", bus.tick, 1'b0);
    chk("async_running", bus.running, 1'b0);
    chk("async_level", bus.level, 8'd0);
    chk("async_period", bus.period, 16'd10);
    drain("reset_drain");
    @(negedge sysclk) rst_n = 1'b1;
    ticks_seen = 0;
    repeat (12) step();
    chk("post_reset_running", bus.running, 1'b0);
    chk("post_reset_ticks", ticks_seen, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/speed_tick_scheduler.md
SPEED_TICK_SCHEDULER -- requirements
Module: speed_tick_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CW, 32, width of period counter and period register.
- PERIOD_INIT, 1000000, initial tick period in sysclk cycles (100 Hz at 100 MHz).
- PERIOD_MIN, 250000, floor for the tick period.
- PERIOD_STEP, 50000, period decrement applied per level-up.
- TICKS_PER_LEVEL, 500, ticks per level-up.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- sysclk, input, 1, system clock (100 MHz).
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin or resume the game (level-sensitive, sampled each edge).
- pause, input, 1, freeze scheduling.
- stop, input, 1, game over; return to idle.
- tick, output, 1, registered one-cycle game-step enable.
- running, output, 1, high while in RUN.
- level, output, 8, current difficulty level.
- period, output, CW, active tick period in cycles.
REQ-003 The block SHALL use one clock, sysclk; reset SHALL be asynchronous and active-low on rst_n.
REQ-004 tick SHALL be a clock-enable pulse; the block SHALL NOT generate derived clocks.

Function
REQ-005 The FSM SHALL have states IDLE, RUN and PAUSED; input priority SHALL be stop > pause > start.
REQ-006 Transitions: IDLE->RUN on start; RUN->PAUSED on pause; PAUSED->RUN on start with pause low; any state->IDLE on stop; start in RUN SHALL be ignored.
REQ-007 Entry to IDLE SHALL clear the counter, tick count and level to 0 and load period with PERIOD_INIT.
REQ-008 In RUN: if counter == period-1, the counter SHALL reset to 0 and tick SHALL be registered high; otherwise the counter SHALL increment and tick SHALL be registered low.
REQ-009 Outside RUN, tick SHALL be registered low and the counter SHALL hold.
REQ-010 The first tick SHALL appear exactly PERIOD_INIT cycles after the edge that samples start in IDLE; subsequent ticks SHALL be spaced by exactly period cycles.
REQ-011 Pause SHALL extend the current interval by exactly the number of cycles spent in PAUSED; counter phase SHALL be preserved.
REQ-012 stop or pause on the cycle the counter is at period-1 SHALL suppress that tick; after pause, the tick SHALL fire on the first RUN cycle.
REQ-013 Every tick SHALL increment the tick count; when it reaches TICKS_PER_LEVEL, it SHALL clear, level SHALL increment (saturating at 255), and period SHALL become max(period-PERIOD_STEP, PERIOD_MIN).
REQ-014 The period subtraction SHALL be computed without unsigned underflow; the new period SHALL take effect from the interval starting after the level-up tick.
REQ-015 running SHALL equal (state == RUN), registered.
REQ-016 Elaboration SHALL reject PERIOD_MIN < 2, PERIOD_INIT < PERIOD_MIN, or PERIOD_INIT >= 2^CW.

Reset
REQ-017 On rst_n low, the block SHALL immediately enter IDLE with tick=0, running=0, level=0, period=PERIOD_INIT, counter=0 and tick count 0, including mid-RUN or mid-PAUSED.
REQ-018 After rst_n deasserts, the block SHALL remain in IDLE until start is sampled high.

Configuration
REQ-019 With macro SPEED_TICK_RAMP_EN defined, the level and period ramp of REQ-013/014 SHALL be compiled in.
REQ-020 Without SPEED_TICK_RAMP_EN, the ramp logic SHALL be absent; level SHALL be constant 0 and period SHALL be constant PERIOD_INIT.

Verification (PERIOD_INIT=10, PERIOD_MIN=4, PERIOD_STEP=3, TICKS_PER_LEVEL=2, macro defined)
REQ-021 start pulse in IDLE -> tick high exactly 10 cycles later, then every 10 cycles; running=1.
REQ-022 Continuous run -> after tick 2: level=1, period=7; after tick 4: level=2, period=4; after tick 6: level=3, period=4 (floor held).
REQ-023 pause held 5 cycles at counter=3, then start -> next tick 5 cycles later than unpaused; pause asserted at counter=9 -> no tick until first RUN cycle after resume.
REQ-024 stop, pause and start high together in RUN -> IDLE next edge, level=0, period=10, running=0, no tick.
REQ-025 rst_n pulled low mid-RUN between edges -> tick=0, running=0, level=0 and period=10 immediately, without a clock edge.
REQ-026 Macro undefined, 30 ticks -> level stays 0 and period stays 10 throughout.
